mem_access_unit: RTL and testbench

- Load/store sequencer that sits directly upstream of MEMSTAGE, between the EX/MEM pipeline register and the data memory.
- MEMSTAGE is word-only. This block adds the byte operations: byte loads (LB, LBU) and byte stores (SB). SB is done as read-modify-write.
- It forces word alignment on the address presented to memory and stalls the pipeline while a multi-cycle access is in flight.

---
 rtl/mem_pkg.sv | 30 +++
 rtl/byte_lane_unit.sv | 35 +++
 rtl/mem_access_unit.sv | 175 +++++++++++++++++
 tb/tb_mem_access_unit.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
// ============================================================================
// Module  : mem_pkg
// Brief   : Shared op codes, FSM states and byte-lane constants for the
//           memory access unit and its byte-lane helper.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package mem_pkg;

  // Width of one byte lane inside a memory word
  localparam int BYTE_W = 8;

  // Operation codes carried on req_op
  localparam logic [2:0] OP_LW  = 3'b000;
  localparam logic [2:0] OP_LB  = 3'b001;
  localparam logic [2:0] OP_LBU = 3'b010;
  localparam logic [2:0] OP_SW  = 3'b100;
  localparam logic [2:0] OP_SB  = 3'b101;

  // Sequencer states
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RD   = 2'd1,
    ST_WR   = 2'd2
  } state_t;

endpackage

`default_nettype wire

// File: rtl/byte_lane_unit.sv
// ============================================================================
// Module  : byte_lane_unit
// Brief   : Combinational byte-lane helper. Extracts and sign/zero-extends
//           one little-endian byte of a word for loads, and merges a byte
//           into a word for read-modify-write byte stores.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module byte_lane_unit
  import mem_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic [DATA_W-1:0] word_in,
  input  logic [1:0]        lane,
  input  logic              sign_ext,
  input  logic [BYTE_W-1:0] byte_in,
  output logic [DATA_W-1:0] load_ext,
  output logic [DATA_W-1:0] merged
);

  logic [BYTE_W-1:0] sel_byte;

  // Select byte k = bits [8k+7:8k], extend it, and build the merged word
  always_comb begin
    sel_byte = word_in[{lane, 3'b000} +: BYTE_W];
    load_ext = {{(DATA_W-BYTE_W){sign_ext & sel_byte[BYTE_W-1]}}, sel_byte};
    merged   = word_in;
    merged[{lane, 3'b000} +: BYTE_W] = byte_in;
  end

endmodule

`default_nettype wire

// File: rtl/mem_access_unit.sv
// ============================================================================
// Module  : mem_access_unit
// Brief   : Load/store sequencer in front of a word-only memory stage.
//           Adds LB/LBU byte loads and SB byte stores (read-modify-write),
//           forces word alignment and stalls during multi-cycle accesses.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_access_unit
  import mem_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  input  logic [2:0]        req_op,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              stall,
  output logic              load_valid,
  output logic [DATA_W-1:0] load_data,
  output logic              align_err,
  output logic              Mem_WrEn,
  output logic [ADDR_W-1:0] ALU_MEM_Addr,
  output logic [DATA_W-1:0] MEM_DataIn,
  input  logic [DATA_W-1:0] MEM_DataOut
);

  state_t            state_q, state_d;
  logic [2:0]        op_q, op_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [1:0]        lane_q, lane_d;
  logic [BYTE_W-1:0] byte_q, byte_d;
  logic [DATA_W-1:0] wbuf_q, wbuf_d;
  logic [DATA_W-1:0] load_data_q, load_data_d;
  logic              load_valid_q, load_valid_d;
  logic              align_err_q, align_err_d;

  logic              stall_c;
  logic              wr_en_c;
  logic [ADDR_W-1:0] mem_addr_c;
  logic [DATA_W-1:0] mem_din_c;
  logic              start_rd;
  logic              misaligned;
  logic [ADDR_W-1:0] req_word_addr;
  logic [DATA_W-1:0] lane_ext;
  logic [DATA_W-1:0] lane_merged;

  assign req_word_addr = {req_addr[ADDR_W-1:2], 2'b00};
  assign misaligned    = |req_addr[1:0];

  byte_lane_unit #(
    .DATA_W (DATA_W)
  ) u_byte_lane (
    .word_in  (MEM_DataOut),
    .lane     (lane_q),
    .sign_ext (op_q == OP_LB),
    .byte_in  (byte_q),
    .load_ext (lane_ext),
    .merged   (lane_merged)
  );

  // Next-state and memory-side control; everything defaults to hold/idle
  always_comb begin
    state_d      = state_q;
    op_d         = op_q;
    addr_d       = addr_q;
    lane_d       = lane_q;
    byte_d       = byte_q;
    wbuf_d       = wbuf_q;
    load_data_d  = load_data_q;
    load_valid_d = 1'b0;
    align_err_d  = 1'b0;
    stall_c      = 1'b0;
    wr_en_c      = 1'b0;
    mem_addr_c   = addr_q;
    mem_din_c    = '0;
    start_rd     = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          case (req_op)
            OP_SW: begin
              if (misaligned) begin
                align_err_d = 1'b1;
              end else begin
                // Aligned word store completes in the acceptance cycle
                wr_en_c    = 1'b1;
                mem_addr_c = req_word_addr;
                mem_din_c  = req_wdata;
                addr_d     = req_word_addr;
              end
            end
            OP_LW: begin
              if (misaligned) align_err_d = 1'b1;
              else            start_rd    = 1'b1;
            end
            OP_LB, OP_LBU, OP_SB: start_rd = 1'b1;
            default: ;
          endcase
        end
        // Loads and byte stores all begin with a word read
        if (start_rd) begin
          mem_addr_c = req_word_addr;
          addr_d     = req_word_addr;
          op_d       = req_op;
          lane_d     = req_addr[1:0];
          byte_d     = req_wdata[BYTE_W-1:0];
          stall_c    = 1'b1;
          state_d    = ST_RD;
        end
      end
      ST_RD: begin
        stall_c = 1'b1;
        if (op_q == OP_SB) begin
          wbuf_d  = lane_merged;
          state_d = ST_WR;
        end else begin
          load_data_d  = (op_q == OP_LW) ? MEM_DataOut : lane_ext;
          load_valid_d = 1'b1;
          state_d      = ST_IDLE;
        end
      end
      ST_WR: begin
        stall_c   = 1'b1;
        wr_en_c   = 1'b1;
        mem_din_c = wbuf_q;
        state_d   = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and data registers with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      op_q         <= '0;
      addr_q       <= '0;
      lane_q       <= '0;
      byte_q       <= '0;
      wbuf_q       <= '0;
      load_data_q  <= '0;
      load_valid_q <= 1'b0;
      align_err_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      op_q         <= op_d;
      addr_q       <= addr_d;
      lane_q       <= lane_d;
      byte_q       <= byte_d;
      wbuf_q       <= wbuf_d;
      load_data_q  <= load_data_d;
      load_valid_q <= load_valid_d;
      align_err_q  <= align_err_d;
    end
  end

  // Combinational outputs are forced to zero while reset is asserted so a
  // reset landing on the write cycle of a byte store cannot corrupt memory
  assign stall        = stall_c & ~reset;
  assign Mem_WrEn     = wr_en_c & ~reset;
  assign ALU_MEM_Addr = reset ? '0 : mem_addr_c;
  assign MEM_DataIn   = reset ? '0 : mem_din_c;
  assign load_valid   = load_valid_q;
  assign load_data    = load_data_q;
  assign align_err    = align_err_q;

endmodule

`default_nettype wire

// File: tb/tb_mem_access_unit.sv
// ============================================================================
// Module  : tb_mem_access_unit
// Brief   : Self-checking bench for mem_access_unit: directed vector table,
//           hand-written multi-cycle sequences and randomized operations
//           compared against a byte-addressed reference memory.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mem_access_unit;
  import mem_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid;
  logic [2:0]  req_op;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        stall;
  logic        load_valid;
  logic [31:0] load_data;
  logic        align_err;
  logic        Mem_WrEn;
  logic [31:0] ALU_MEM_Addr;
  logic [31:0] MEM_DataIn;
  logic [31:0] MEM_DataOut;

  int n_chk  = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  mem_access_unit #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk          (clk),
    .reset        (reset),
    .req_valid    (req_valid),
    .req_op       (req_op),
    .req_addr     (req_addr),
    .req_wdata    (req_wdata),
    .stall        (stall),
    .load_valid   (load_valid),
    .load_data    (load_data),
    .align_err    (align_err),
    .Mem_WrEn     (Mem_WrEn),
    .ALU_MEM_Addr (ALU_MEM_Addr),
    .MEM_DataIn   (MEM_DataIn),
    .MEM_DataOut  (MEM_DataOut)
  );

  // Word memory: write at clock edge, read data one cycle after address
  logic        mem_clr;
  logic [31:0] mem [0:15];
  logic [31:0] mem_rd;
  always @(posedge clk) begin
    if (mem_clr) begin
      for (int i = 0; i < 16; i++) mem[i] <= '0;
      mem_rd <= '0;
    end else begin
      if (Mem_WrEn) mem[ALU_MEM_Addr[5:2]] <= MEM_DataIn;
      mem_rd <= mem[ALU_MEM_Addr[5:2]];
    end
  end
  assign MEM_DataOut = mem_rd;

  // Reference memory, updated with architectural load/store semantics
  logic [31:0] ref_mem [0:15];

  function automatic logic [31:0] ref_load(input logic [2:0] op, input logic [31:0] a);
    logic [31:0] w, b;
    int sh;
    w  = ref_mem[a[5:2]];
    sh = 8 * int'(a[1:0]);
    b  = (w >> sh) & 32'hFF;
    if (op == OP_LW)       return w;
    else if (op == OP_LBU) return b;
    else                   return (b >= 32'd128) ? b + 32'hFFFF_FF00 : b;
  endfunction

  function automatic logic [31:0] ref_sb(input logic [31:0] a, input logic [31:0] d);
    logic [31:0] w;
    int sh;
    w  = ref_mem[a[5:2]];
    sh = 8 * int'(a[1:0]);
    return (w & ~(32'hFF << sh)) | ((d & 32'hFF) << sh);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %08h expected %08h (t=%0t)", name, act, exp, $time);
  endtask

  task automatic drive(input logic v, input logic [2:0] o, input logic [31:0] a, input logic [31:0] d);
    req_valid = v;
    req_op    = o;
    req_addr  = a;
    req_wdata = d;
  endtask

  // One operation from idle, observed over four cycles. Latencies follow
  // the operation class: loads stall 2 cycles, SB stalls 3, SW none.
  task automatic run_op(input logic [2:0] op, input logic [31:0] addr,
                        input logic [31:0] wdata, output logic [31:0] got);
    logic        is_ld, mis, ld, sb, sw;
    int          nst, wr_cyc;
    logic [31:0] wa, expd, expw;
    is_ld  = (op == OP_LW) || (op == OP_LB) || (op == OP_LBU);
    mis    = ((op == OP_LW) || (op == OP_SW)) && (addr[1:0] != 2'b00);
    ld     = is_ld && !mis;
    sb     = (op == OP_SB);
    sw     = (op == OP_SW) && !mis;
    nst    = ld ? 2 : (sb ? 3 : 0);
    wr_cyc = sw ? 0 : (sb ? 2 : -1);
    wa     = {addr[31:2], 2'b00};
    expd   = ref_load(op, addr);
    expw   = sb ? ref_sb(addr, wdata) : wdata;
    got    = '0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      if (k == 0)        drive(1'b1, op, addr, wdata);
      else if (k < nst)  drive(1'b1, 3'($urandom), $urandom_range(0, 63), $urandom);
      else               drive(1'b0, 3'($urandom), $urandom_range(0, 63), $urandom);
      #1;
      chk("stall", {31'b0, stall}, {31'b0, k < nst});
      chk("mem_wren", {31'b0, Mem_WrEn}, {31'b0, k == wr_cyc});
      if (k == wr_cyc) chk("wr_data", MEM_DataIn, expw);
      if (k < nst || k == wr_cyc) chk("mem_addr", ALU_MEM_Addr, wa);
      chk("load_valid", {31'b0, load_valid}, {31'b0, ld && (k == 2)});
      if (ld && k == 2) begin
        chk("load_data", load_data, expd);
        got = load_data;
      end
      chk("align_err", {31'b0, align_err}, {31'b0, mis && (k == 1)});
    end
    if (sw || sb) ref_mem[addr[5:2]] = expw;
  endtask

  typedef struct {
    logic [2:0]  op;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp;
    logic        has_exp;
  } vec_t;

  vec_t        tv [10];
  logic [31:0] got;
  logic [2:0]  ops [8];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < 16; i++) ref_mem[i] = '0;
    tv[0] = '{OP_SW,  32'h10, 32'hA1B2C3D4, 32'h0,         1'b0};
    tv[1] = '{OP_LW,  32'h10, 32'h0,        32'hA1B2C3D4,  1'b1};
    tv[2] = '{OP_LB,  32'h13, 32'h0,        32'hFFFFFFA1,  1'b1};
    tv[3] = '{OP_LBU, 32'h13, 32'h0,        32'h000000A1,  1'b1};
    tv[4] = '{OP_LB,  32'h10, 32'h0,        32'hFFFFFFD4,  1'b1};
    tv[5] = '{OP_SB,  32'h11, 32'h000000EE, 32'h0,         1'b0};
    tv[6] = '{OP_LW,  32'h10, 32'h0,        32'hA1B2EED4,  1'b1};
    tv[7] = '{OP_LW,  32'h12, 32'h0,        32'h0,         1'b0};
    tv[8] = '{OP_SW,  32'h01, 32'hDEADBEEF, 32'h0,         1'b0};
    tv[9] = '{OP_SW,  32'h10, 32'hA1B2C3D4, 32'h0,         1'b0};
    ops = '{OP_LW, OP_LB, OP_LBU, OP_SW, OP_SB, 3'b011, 3'b110, 3'b111};

    // Reset: all outputs zero, even with a store request pending
    mem_clr = 1'b1;
    reset   = 1'b1;
    drive(1'b1, OP_SW, 32'h10, 32'h12345678);
    repeat (2) @(posedge clk);
    @(negedge clk);
    #1;
    chk("rst_stall",     {31'b0, stall},      32'h0);
    chk("rst_wren",      {31'b0, Mem_WrEn},   32'h0);
    chk("rst_addr",      ALU_MEM_Addr,        32'h0);
    chk("rst_din",       MEM_DataIn,          32'h0);
    chk("rst_lvalid",    {31'b0, load_valid}, 32'h0);
    chk("rst_ldata",     load_data,           32'h0);
    chk("rst_align",     {31'b0, align_err},  32'h0);
    @(negedge clk);
    reset   = 1'b0;
    mem_clr = 1'b0;
    drive(1'b0, OP_LW, 32'h0, 32'h0);

    // Directed vector table
    for (int i = 0; i < 10; i++) begin
      run_op(tv[i].op, tv[i].addr, tv[i].wdata, got);
      if (tv[i].has_exp) chk("tv_data", got, tv[i].exp);
    end
    chk("mis_sw_word0", mem[0], 32'h0);
    chk("restore_word", mem[4], 32'hA1B2C3D4);

    // Reset landing on the write cycle of SB 0x11
    @(negedge clk); drive(1'b1, OP_SB, 32'h11, 32'h000000EE);
    @(negedge clk); drive(1'b0, OP_LW, 32'h0, 32'h0);
    @(negedge clk); reset = 1'b1;
    #1;
    chk("rstwr_wren",  {31'b0, Mem_WrEn}, 32'h0);
    @(negedge clk); reset = 1'b0;
    #1;
    chk("rstwr_stall", {31'b0, stall},      32'h0);
    chk("rstwr_wren2", {31'b0, Mem_WrEn},   32'h0);
    chk("rstwr_addr",  ALU_MEM_Addr,        32'h0);
    chk("rstwr_din",   MEM_DataIn,          32'h0);
    chk("rstwr_lval",  {31'b0, load_valid}, 32'h0);
    chk("rstwr_ldata", load_data,           32'h0);
    chk("rstwr_align", {31'b0, align_err},  32'h0);
    chk("rstwr_mem",   mem[4],              32'hA1B2C3D4);
    run_op(OP_LW, 32'h10, 32'h0, got);
    chk("rstwr_idle_lw", got, 32'hA1B2C3D4);

    // Back-to-back loads: second accepted in the cycle the first completes
    run_op(OP_SW, 32'h14, 32'h0000001F, got);
    @(negedge clk); drive(1'b1, OP_LW, 32'h10, 32'h0);
    #1; chk("b2b_stall_t0", {31'b0, stall}, 32'h1);
    @(negedge clk);
    #1; chk("b2b_stall_t1", {31'b0, stall}, 32'h1);
    @(negedge clk); drive(1'b1, OP_LW, 32'h14, 32'h0);
    #1;
    chk("b2b_lval_t2",  {31'b0, load_valid}, 32'h1);
    chk("b2b_data_t2",  load_data,           32'hA1B2C3D4);
    chk("b2b_stall_t2", {31'b0, stall},      32'h1);
    chk("b2b_addr_t2",  ALU_MEM_Addr,        32'h14);
    @(negedge clk);
    #1;
    chk("b2b_stall_t3", {31'b0, stall},      32'h1);
    chk("b2b_lval_t3",  {31'b0, load_valid}, 32'h0);
    @(negedge clk); drive(1'b0, OP_LW, 32'h0, 32'h0);
    #1;
    chk("b2b_lval_t4",  {31'b0, load_valid}, 32'h1);
    chk("b2b_data_t4",  load_data,           32'h0000001F);
    chk("b2b_stall_t4", {31'b0, stall},      32'h0);

    // Randomized operations against the reference memory
    for (int i = 0; i < 80; i++) begin
      logic [2:0]  rop;
      logic [31:0] raddr;
      rop   = ops[$urandom_range(0, 7)];
      raddr = 32'($urandom_range(0, 63));
      if ((rop == OP_LW || rop == OP_SW) && $urandom_range(0, 3) != 0) raddr[1:0] = 2'b00;
      run_op(rop, raddr, $urandom, got);
    end
    @(negedge clk);
    for (int i = 0; i < 16; i++) chk("final_mem", mem[i], ref_mem[i]);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

`default_nettype wire
